au_neg_seq: RTL and testbench

AU_NEG_SEQ -- requirements
Module: AU_neg_seq

---
 rtl/au_neg_seq_pkg.sv | 21 ++
 rtl/au_neg_c.sv | 29 ++
 rtl/au_neg_seq.sv | 143 ++++++++++++++
 tb/tb_au_neg_seq.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/au_neg_seq_pkg.sv
// Shared arithmetic-unit definitions: FSM state encoding and chunk-count helpers
// used by the chunk-serial negator.
package au_neg_seq_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Number of CHUNK-wide slices needed to cover a WIDTH-bit operand.
    function automatic int nch_f(input int width, input int chunk);
        return (width + chunk - 1) / chunk;
    endfunction

    // Width of a chunk index counting 0..nch-1 (at least one bit).
    function automatic int idx_w_f(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/au_neg_c.sv
// Combinational two's-complement slice negator: z = neg ? -a : a (mod 2^WIDTH).
// ARCH selects between three equivalent structures.
module au_neg_c #(
    parameter int WIDTH = 4,
    parameter int ARCH  = 0
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic             neg_i,
    output logic [WIDTH-1:0] z_o
);

    if (ARCH == 1) begin : g_xor_add
        assign z_o = (a_i ^ {WIDTH{neg_i}}) + WIDTH'(neg_i);
    end else if (ARCH == 2) begin : g_ripple
        // Bits above the lowest set bit are inverted; the rest pass through.
        always_comb begin
            logic seen;
            seen = 1'b0;
            z_o  = '0;
            for (int i = 0; i < WIDTH; i++) begin
                z_o[i] = a_i[i] ^ (neg_i & seen);
                seen   = seen | a_i[i];
            end
        end
    end else begin : g_inv_inc
        assign z_o = neg_i ? (~a_i + WIDTH'(1)) : a_i;
    end

endmodule

// File: rtl/au_neg_seq.sv
// Chunk-serial negator: accepts one operand, negates it CHUNK bits per cycle
// from the LSB upward, and holds the result until the consumer takes it.
module au_neg_seq
    import au_neg_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4,
    parameter int ARCH  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic             neg,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             ovf,
    output logic             busy,
    output state_t           dbg_state
);

    localparam int NCH = nch_f(WIDTH, CHUNK);
    localparam int KW  = idx_w_f(NCH);
    localparam int PW  = NCH * CHUNK;
    localparam logic [WIDTH-1:0] MIN_NEG = WIDTH'(1) << (WIDTH - 1);

    if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || ARCH < 0 || ARCH > 2) begin : g_bad_params
        $fatal(1, "au_neg_seq: illegal parameters WIDTH=%0d CHUNK=%0d ARCH=%0d", WIDTH, CHUNK, ARCH);
    end

    // Handshake: a transfer happens on a rising edge where valid and ready are both
    // high; valid never depends combinationally on ready, and a producer holds its
    // data stable while valid is high and ready is low.

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic              neg_q, neg_d;
    logic [KW-1:0]     k_q, k_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  z_q, z_d;
    logic              ovf_q, ovf_d;

    logic [PW-1:0]     a_pad;
    logic [CHUNK-1:0]  a_k;
    logic [CHUNK-1:0]  slice_z;
    logic [CHUNK-1:0]  z_k;
    logic              last_chunk;

    assign a_pad      = PW'(a_q);
    assign last_chunk = (k_q == KW'(NCH - 1));

    always_comb begin
        a_k = '0;
        for (int c = 0; c < NCH; c++) begin
            if (k_q == KW'(c)) a_k = a_pad[c*CHUNK +: CHUNK];
        end
    end

    au_neg_c #(
        .WIDTH (CHUNK),
        .ARCH  (ARCH)
    ) u_slice (
        .a_i   (a_k),
        .neg_i (neg_q & carry_q),
        .z_o   (slice_z)
    );

    // Once the borrow chain has died, the remaining chunks are a plain inversion.
    always_comb begin
        if (!neg_q)       z_k = a_k;
        else if (carry_q) z_k = slice_z;
        else              z_k = ~a_k;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        neg_d   = neg_q;
        k_d     = k_q;
        carry_d = carry_q;
        z_d     = z_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    neg_d   = neg;
                    k_d     = '0;
                    carry_d = neg;
                    ovf_d   = 1'b0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Only bits that belong to the live chunk and to the real word are written.
                for (int i = 0; i < WIDTH; i++) begin
                    if (k_q == KW'(i / CHUNK)) z_d[i] = z_k[i % CHUNK];
                end
                carry_d = carry_q & (a_k == '0);
                if (last_chunk) begin
                    ovf_d   = neg_q & (a_q == MIN_NEG);
                    state_d = ST_DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            neg_q   <= 1'b0;
            k_q     <= '0;
            carry_q <= 1'b0;
            z_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            neg_q   <= neg_d;
            k_q     <= k_d;
            carry_q <= carry_d;
            z_q     <= z_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign z         = z_q;
    assign ovf       = ovf_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_au_neg_seq.sv
// Directed and random checks of the chunk-serial negator at WIDTH=10, CHUNK=4.
module tb_au_neg_seq;
    import au_neg_seq_pkg::*;

    localparam int W        = 10;
    localparam int CH       = 4;
    localparam int NCH_EXP  = 3;
    localparam int N_RANDOM = 10000;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic         neg;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] z;
    logic         ovf;
    logic         busy;
    state_t       dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [W:0] exp_q[$];

    au_neg_seq #(.WIDTH(W), .CHUNK(CH), .ARCH(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .neg       (neg),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .ovf       (ovf),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Waits for out_valid; returns cycles counted from the accept edge.
    task automatic wait_out(output int cyc);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 50) begin
            step();
            cyc++;
        end
    endtask

    // driver: one directed operand with hand-computed result
    task automatic run_op(input string tag, input logic [W-1:0] av, input logic nv,
                          input logic [W-1:0] exp_z, input logic exp_ovf);
        int cyc;
        check({tag, ".in_ready"}, in_ready, 1);
        in_valid = 1'b1;
        a        = av;
        neg      = nv;
        step();
        in_valid = 1'b0;
        a        = '0;
        neg      = 1'b0;
        check({tag, ".busy"}, busy, 1);
        wait_out(cyc);
        check({tag, ".latency"}, cyc, NCH_EXP);
        check({tag, ".z"}, z, exp_z);
        check({tag, ".ovf"}, ovf, exp_ovf);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, ".idle"}, in_ready, 1);
        check({tag, ".z_held"}, z, exp_z);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
    endtask

    task automatic random_sweep();
        int   issued = 0;
        int   cycles = 0;
        logic acc, take;
        logic [W:0] exp;
        in_valid  = 1'b1;
        a         = W'($urandom_range(0, (1 << W) - 1));
        neg       = 1'($urandom_range(0, 1));
        out_ready = 1'($urandom_range(0, 7) != 0);
        while ((issued < N_RANDOM || exp_q.size() != 0) && cycles < 90000) begin
            acc  = in_valid & in_ready;
            take = out_valid & out_ready;
            if (take) begin
                if (exp_q.size() == 0) begin
                    check("rand.unexpected_output", 1, 0);
                end else begin
                    exp = exp_q.pop_front();
                    check("rand.z", z, exp[W-1:0]);
                    check("rand.ovf", ovf, exp[W]);
                end
            end
            if (acc) begin
                exp_q.push_back({neg && (a == W'(1 << (W - 1))), neg ? W'(-a) : a});
                issued++;
            end
            step();
            cycles++;
            if (acc) begin
                if (issued < N_RANDOM) begin
                    a   = W'($urandom_range(0, (1 << W) - 1));
                    neg = 1'($urandom_range(0, 1));
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = 1'($urandom_range(0, 7) != 0);
        end
        check("rand.timeout", (cycles < 90000) ? 1 : 0, 1);
        check("rand.issued", issued, N_RANDOM);
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        int cyc;
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        neg       = 1'b0;
        out_ready = 1'b0;
        do_reset();

        check("reset.in_ready", in_ready, 1);
        check("reset.out_valid", out_valid, 0);
        check("reset.busy", busy, 0);
        check("reset.z", z, 0);
        check("reset.ovf", ovf, 0);

        run_op("neg_one",  10'h001, 1'b1, 10'h3FF, 1'b0);
        run_op("min_neg",  10'h200, 1'b1, 10'h200, 1'b1);
        run_op("neg_zero", 10'h000, 1'b1, 10'h000, 1'b0);
        run_op("pass",     10'h155, 1'b0, 10'h155, 1'b0);
        run_op("carry_x",  10'h010, 1'b1, 10'h3F0, 1'b0);
        run_op("pass_min", 10'h200, 1'b0, 10'h200, 1'b0);

        // stall in DONE with stray in_valid pulses
        in_valid = 1'b1;
        a        = 10'h123;
        neg      = 1'b1;
        step();
        in_valid = 1'b0;
        wait_out(cyc);
        check("stall.latency", cyc, NCH_EXP);
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            a        = 10'h3AA;
            neg      = 1'b0;
            out_ready = 1'b0;
            step();
            check("stall.z", z, 10'h2DD);
            check("stall.ovf", ovf, 0);
            check("stall.out_valid", out_valid, 1);
            check("stall.in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("stall.release_idle", in_ready, 1);
        check("stall.release_valid", out_valid, 0);
        step();
        check("stall.no_accept", busy, 0);

        // reset in mid-RUN discards the partial result
        in_valid = 1'b1;
        a        = 10'h2C7;
        neg      = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        out_ready = 1'b1;
        step();
        rst = 1'b0;
        out_ready = 1'b0;
        check("rst_run.in_ready", in_ready, 1);
        check("rst_run.out_valid", out_valid, 0);
        check("rst_run.z", z, 0);
        check("rst_run.busy", busy, 0);
        run_op("after_rst", 10'h0FF, 1'b1, 10'h301, 1'b0);

        // reset in DONE with out_ready high
        in_valid = 1'b1;
        a        = 10'h200;
        neg      = 1'b1;
        step();
        in_valid = 1'b0;
        wait_out(cyc);
        rst       = 1'b1;
        out_ready = 1'b1;
        step();
        rst       = 1'b0;
        out_ready = 1'b0;
        check("rst_done.out_valid", out_valid, 0);
        check("rst_done.ovf", ovf, 0);
        check("rst_done.z", z, 0);

        random_sweep();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
